lcd_bus_rd: RTL and testbench
=============================

Name: lcd_bus_rd

Overview:
Read-side bus engine for the HD44780-style character LCD on the DE2 board; the counterpart of the write path that pushes text lines.
- Performs single LCD read cycles with RWF=1: busy-flag/address-counter read (RS=0) or DDRAM/CGRAM data read (RS=1).
- Optionally polls the busy flag until it clears.
- Sits beside the write bus engine; a top-level mux gives it bus ownership while O_BUSY=1.

Parameters:
- T_AS_CYC, 3: cycles of RS/RWF setup before EN rises (≥1).
- T_EN_CYC, 25: cycles EN held high (≥3).
- T_HOLD_CYC, 3: cycles RS/RWF held after EN falls (≥1).
- T_GAP_CYC, 20: idle cycles after HOLD before the next poll or DONE (≥1).
- POLL_MAX, 1000: maximum busy-flag read attempts in poll mode before timeout (≥1).

Ports:
- I_CLK  in  1  clock
- I_RSTF  in  1  reset, asynchronous, active-low
- O_LCD_EN  out  1  LCD enable strobe
- O_LCD_RS  out  1  register select: 0 = busy/address, 1 = data
- O_LCD_RWF  out  1  read/write select: 1 = read
- I_LCD_DATA  in  8  LCD data bus input
- O_LCD_DATA_OE  out  1  FPGA data-bus drive permitted; 0 while this block owns the bus
- I_START  in  1  request a read; sampled only in IDLE
- I_RS  in  1  register select for the request; latched at accept
- I_POLL  in  1  repeat RS=0 reads until BF=0; latched at accept; ignored when I_RS=1
- O_RDATA  out  8  last captured read byte
- O_BUSY  out  1  transaction in progress (not IDLE)
- O_DONE  out  1  one-cycle completion pulse
- O_TIMEOUT  out  1  set with O_DONE when poll count hits POLL_MAX; cleared at next accept

Behaviour:
- Reset values: O_LCD_EN=0, O_LCD_RS=0, O_LCD_RWF=0, O_LCD_DATA_OE=1, O_RDATA=0, O_BUSY=0, O_DONE=0, O_TIMEOUT=0. State=IDLE, counters=0.
- Reset mid-operation: async return to reset values at once. No partial-cycle completion; no O_DONE.
- States and transitions:
  - IDLE -> SETUP when I_START=1 (accept cycle).
  - SETUP (T_AS_CYC) -> EN_HI (T_EN_CYC) -> HOLD (T_HOLD_CYC) -> GAP (T_GAP_CYC).
  - GAP -> SETUP if polling and BF=1 and attempts<POLL_MAX; otherwise GAP -> DONE.
  - DONE (1 cycle) -> IDLE.
- Output drive by state:
  - SETUP through HOLD: RWF=1, RS=latched I_RS, DATA_OE=0.
  - EN=1 only in EN_HI.
  - GAP: RWF=0, EN=0, DATA_OE=0, RS held.
  - DONE and IDLE: DATA_OE=1, RWF=0.
- Capture: an input stage registers I_LCD_DATA every cycle. On the first HOLD cycle (EN fall), O_RDATA <= stage output. O_RDATA holds until the next capture.
- Latency with defaults: accept at cycle 0; SETUP 1-3; EN_HI 4-28; HOLD 29-31; GAP 32-51; O_DONE high in cycle 52. General form: T_AS+T_EN+T_HOLD+T_GAP+1 cycles per attempt.
- Poll mode:
  - Each attempt increments a 16-bit attempt counter.
  - BF = O_RDATA[7] of the current attempt.
  - Terminates on BF=0 (O_TIMEOUT=0) or attempts==POLL_MAX with BF=1 (O_TIMEOUT=1, O_DONE in the same cycle).
- I_START while O_BUSY=1 is ignored and not queued. I_START high in the DONE cycle is ignored. I_START held high continuously re-accepts in the IDLE cycle following DONE.
- Changes on I_RS/I_POLL after accept have no effect on the current transaction.
- O_BUSY=1 from the cycle after accept through the DONE cycle inclusive.

Optional Feature:
LCD_RD_SYNC_EN:
- Defined: input stage is two flops, and captured data is I_LCD_DATA as sampled 2 edges before EN fall. Requires T_EN_CYC≥3; latency unchanged.
- Undefined: single flop, and captured data is the value at the last EN-high edge.

Test Plan:
- Reset mid-EN_HI (cycle 10) -> EN, RWF, O_BUSY drop to 0 asynchronously and DATA_OE=1; no O_DONE; next I_START runs a full 52-cycle transaction.
- I_START=1, I_RS=1, LCD model drives 0x41 during EN high -> RS=1, RWF=1 in cycles 1-31, EN=1 in cycles 4-28, O_RDATA=0x41 from cycle 29, O_DONE pulse cycle 52, O_TIMEOUT=0.
- I_RS=0, I_POLL=1, model returns 0x85, 0x85, then 0x05 -> three EN pulses, O_RDATA=0x05, O_DONE at cycle 3×52 = 156, O_TIMEOUT=0.
- POLL_MAX=4, model always returns 0x80 -> exactly 4 EN pulses, O_DONE with O_TIMEOUT=1, O_RDATA=0x80; O_TIMEOUT clears at next accept.
- I_START pulsed during EN_HI; I_RS toggled after accept -> second request ignored, single O_DONE, RS output stays at the latched value.
- LCD_RD_SYNC_EN defined, data changes 0x12->0x34 one cycle before EN fall -> O_RDATA=0x12. Undefined -> O_RDATA=0x34.

Source files
------------

// File: rtl/lcd_bus_rd.sv
// Read-side bus engine for the HD44780 LCD: single busy/address or data reads, optional busy-flag polling.
// Build option: define LCD_RD_SYNC_EN for a two-flop input stage on I_LCD_DATA (default: one flop).
module lcd_bus_rd #(
    parameter int T_AS_CYC   = 3,
    parameter int T_EN_CYC   = 25,
    parameter int T_HOLD_CYC = 3,
    parameter int T_GAP_CYC  = 20,
    parameter int POLL_MAX   = 1000
) (
    input  logic       I_CLK,
    input  logic       I_RSTF,
    output logic       O_LCD_EN,
    output logic       O_LCD_RS,
    output logic       O_LCD_RWF,
    input  logic [7:0] I_LCD_DATA,
    output logic       O_LCD_DATA_OE,
    input  logic       I_START,
    input  logic       I_RS,
    input  logic       I_POLL,
    output logic [7:0] O_RDATA,
    output logic       O_BUSY,
    output logic       O_DONE,
    output logic       O_TIMEOUT
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_EN_HI = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;
    localparam logic [2:0] S_RETRY = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    localparam logic [15:0] C_AS   = 16'(T_AS_CYC - 1);
    localparam logic [15:0] C_EN   = 16'(T_EN_CYC - 1);
    localparam logic [15:0] C_HOLD = 16'(T_HOLD_CYC - 1);
    localparam logic [15:0] C_GAP  = 16'(T_GAP_CYC - 1);
    localparam logic [15:0] C_PMAX = 16'(POLL_MAX);

    logic [2:0]  r_state;
    logic [15:0] r_cnt;
    logic [15:0] r_attempts;
    logic        r_rs;
    logic        r_poll;
    logic        r_timeout;
    logic [7:0]  r_rdata;
    logic [7:0]  w_stage;
    logic        w_cnt_zero;
    logic        w_retry;

`ifdef LCD_RD_SYNC_EN
    logic [7:0] r_stage1;
    logic [7:0] r_stage2;

    always_ff @(posedge I_CLK or negedge I_RSTF) begin
        if (!I_RSTF) begin
            r_stage1 <= 8'h00;
            r_stage2 <= 8'h00;
        end else begin
            r_stage1 <= I_LCD_DATA;
            r_stage2 <= r_stage1;
        end
    end
    assign w_stage = r_stage2;
`else
    logic [7:0] r_stage1;

    always_ff @(posedge I_CLK or negedge I_RSTF) begin
        if (!I_RSTF) r_stage1 <= 8'h00;
        else         r_stage1 <= I_LCD_DATA;
    end
    assign w_stage = r_stage1;
`endif

    assign w_cnt_zero = (r_cnt == 16'd0);
    // Another attempt only while the busy flag of this attempt is still set and budget remains.
    assign w_retry    = r_poll && r_rdata[7] && (r_attempts < C_PMAX);

    always_ff @(posedge I_CLK or negedge I_RSTF) begin
        if (!I_RSTF) begin
            r_state    <= S_IDLE;
            r_cnt      <= 16'd0;
            r_attempts <= 16'd0;
            r_rs       <= 1'b0;
            r_poll     <= 1'b0;
            r_timeout  <= 1'b0;
            r_rdata    <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (I_START) begin
                        r_state    <= S_SETUP;
                        r_cnt      <= C_AS;
                        r_rs       <= I_RS;
                        r_poll     <= I_POLL & ~I_RS;
                        r_attempts <= 16'd1;
                        r_timeout  <= 1'b0;
                    end
                end
                S_SETUP: begin
                    if (w_cnt_zero) begin
                        r_state <= S_EN_HI;
                        r_cnt   <= C_EN;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                S_EN_HI: begin
                    if (w_cnt_zero) begin
                        r_state <= S_HOLD;
                        r_cnt   <= C_HOLD;
                        r_rdata <= w_stage;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                S_HOLD: begin
                    if (w_cnt_zero) begin
                        r_state <= S_GAP;
                        r_cnt   <= C_GAP;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                S_GAP: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - 16'd1;
                    end else if (w_retry) begin
                        r_state <= S_RETRY;
                    end else begin
                        r_state   <= S_DONE;
                        r_timeout <= r_poll & r_rdata[7];
                    end
                end
                // Re-issue cycle mirrors the accept cycle so every attempt spans the same length.
                S_RETRY: begin
                    r_state    <= S_SETUP;
                    r_cnt      <= C_AS;
                    r_attempts <= r_attempts + 16'd1;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign O_LCD_EN      = (r_state == S_EN_HI);
    assign O_LCD_RWF     = (r_state == S_SETUP) || (r_state == S_EN_HI) || (r_state == S_HOLD);
    assign O_LCD_RS      = r_rs;
    assign O_LCD_DATA_OE = (r_state == S_IDLE) || (r_state == S_DONE);
    assign O_RDATA       = r_rdata;
    assign O_BUSY        = (r_state != S_IDLE);
    assign O_DONE        = (r_state == S_DONE);
    assign O_TIMEOUT     = r_timeout;
endmodule

// File: tb/tb_lcd_bus_rd.sv
// Bench for lcd_bus_rd: directed cases plus random reads/polls against a per-attempt timing model.
module tb_lcd_bus_rd;
    localparam int PMAX = 4;
    localparam int ATT  = 52;

    logic       I_CLK;
    logic       I_RSTF;
    logic       O_LCD_EN;
    logic       O_LCD_RS;
    logic       O_LCD_RWF;
    logic [7:0] I_LCD_DATA;
    logic       O_LCD_DATA_OE;
    logic       I_START;
    logic       I_RS;
    logic       I_POLL;
    logic [7:0] O_RDATA;
    logic       O_BUSY;
    logic       O_DONE;
    logic       O_TIMEOUT;

    lcd_bus_rd #(.POLL_MAX(PMAX)) dut (
        .I_CLK(I_CLK), .I_RSTF(I_RSTF),
        .O_LCD_EN(O_LCD_EN), .O_LCD_RS(O_LCD_RS), .O_LCD_RWF(O_LCD_RWF),
        .I_LCD_DATA(I_LCD_DATA), .O_LCD_DATA_OE(O_LCD_DATA_OE),
        .I_START(I_START), .I_RS(I_RS), .I_POLL(I_POLL),
        .O_RDATA(O_RDATA), .O_BUSY(O_BUSY), .O_DONE(O_DONE), .O_TIMEOUT(O_TIMEOUT)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] resp_q[$];
    logic [7:0] tx_resp[$];
    logic       late_change = 1'b0;
    logic [7:0] late_val = 8'h00;

    initial begin
        I_CLK = 1'b0;
        forever #5 I_CLK = ~I_CLK;
    end

    // LCD model: presents the next queued byte at each EN rise.
    initial begin
        I_LCD_DATA = 8'h00;
        forever begin
            @(posedge O_LCD_EN);
            if (resp_q.size() > 0) I_LCD_DATA = resp_q.pop_front();
            if (late_change) begin
                repeat (23) @(posedge I_CLK);
                #1 I_LCD_DATA = late_val;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // mode 0: plain, 1: extra I_START and I_RS toggle mid-transaction, 2: late data change
    task automatic run_txn(input logic rs, input logic poll, input int mode);
        int n, k, done_k, pulses, first_en, en_cyc, rwf_cyc, rs_bad, oe_bad, busy_bad, extra_done;
        logic [7:0] exp_d;
        logic exp_t, prev_en;
        n = 1; exp_d = tx_resp[0]; exp_t = 1'b0;
        if (!rs && poll) begin
            for (int i = 0; i < tx_resp.size(); i++) begin
                n = i + 1;
                exp_d = tx_resp[i];
                if (!exp_d[7] || n == PMAX) break;
            end
            exp_t = exp_d[7];
        end
        if (mode == 2) begin
`ifdef LCD_RD_SYNC_EN
            exp_d = tx_resp[0];
`else
            exp_d = late_val;
`endif
        end
        resp_q.delete();
        foreach (tx_resp[i]) resp_q.push_back(tx_resp[i]);
        late_change = (mode == 2);

        @(negedge I_CLK);
        I_START = 1'b1; I_RS = rs; I_POLL = poll;
        @(posedge I_CLK);
        #1 I_START = 1'b0;
        k = 0; done_k = 0; pulses = 0; first_en = 0; en_cyc = 0; rwf_cyc = 0;
        rs_bad = 0; oe_bad = 0; busy_bad = 0; prev_en = 1'b0;
        while (done_k == 0 && k < 1000) begin
            @(negedge I_CLK);
            k++;
            if (mode == 1) begin
                if (k == 10) begin I_START = 1'b1; I_RS = ~rs; I_POLL = ~poll; end
                else if (k == 11) I_START = 1'b0;
            end
            if (k == 1) begin
                check("busy_after_accept", O_BUSY, 1);
                check("timeout_clear_at_accept", O_TIMEOUT, 0);
            end
            if (O_LCD_EN && !prev_en) begin
                pulses++;
                if (first_en == 0) first_en = k;
            end
            prev_en = O_LCD_EN;
            if (O_LCD_EN) en_cyc++;
            if (O_LCD_RWF) rwf_cyc++;
            if (O_LCD_RWF && O_LCD_RS !== rs) rs_bad++;
            if (O_LCD_EN && !O_LCD_RWF) rs_bad++;
            if (O_LCD_RWF && O_LCD_DATA_OE) oe_bad++;
            if (!O_BUSY) busy_bad++;
            if (O_DONE) done_k = k;
        end
        late_change = 1'b0;
        check("done_seen", (done_k != 0), 1);
        check("done_cycle", done_k, ATT * n);
        check("en_pulses", pulses, n);
        check("first_en_cycle", first_en, 4);
        check("en_high_cycles", en_cyc, 25 * n);
        check("rwf_cycles", rwf_cyc, 31 * n);
        check("rs_rwf_bad", rs_bad, 0);
        check("oe_during_read", oe_bad, 0);
        check("busy_gaps", busy_bad, 0);
        check("rdata", O_RDATA, exp_d);
        check("timeout", O_TIMEOUT, exp_t);
        extra_done = 0;
        @(negedge I_CLK);
        check("done_one_cycle", O_DONE, 0);
        check("idle_busy", O_BUSY, 0);
        check("idle_oe", O_LCD_DATA_OE, 1);
        check("idle_rwf", O_LCD_RWF, 0);
        repeat (4) begin
            @(negedge I_CLK);
            if (O_DONE || O_BUSY) extra_done++;
        end
        check("no_extra_txn", extra_done, 0);
    endtask

    initial begin
        int bad;
        I_RSTF = 1'b0; I_START = 1'b0; I_RS = 1'b0; I_POLL = 1'b0;
        repeat (3) @(negedge I_CLK);
        check("rst_en", O_LCD_EN, 0);
        check("rst_rs", O_LCD_RS, 0);
        check("rst_rwf", O_LCD_RWF, 0);
        check("rst_oe", O_LCD_DATA_OE, 1);
        check("rst_rdata", O_RDATA, 0);
        check("rst_busy", O_BUSY, 0);
        check("rst_done", O_DONE, 0);
        check("rst_timeout", O_TIMEOUT, 0);
        I_RSTF = 1'b1;
        repeat (2) @(negedge I_CLK);

        tx_resp = '{8'h41};
        run_txn(1'b1, 1'b0, 0);
        tx_resp = '{8'h85, 8'h85, 8'h05};
        run_txn(1'b0, 1'b1, 0);
        tx_resp = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
        run_txn(1'b0, 1'b1, 0);
        tx_resp = '{8'h80};
        run_txn(1'b1, 1'b1, 0);
        tx_resp = '{8'h5A};
        run_txn(1'b0, 1'b0, 1);
        tx_resp = '{8'h12};
        late_val = 8'h34;
        run_txn(1'b1, 1'b0, 2);

        // Reset in the middle of EN high.
        resp_q.delete();
        resp_q.push_back(8'h77);
        @(negedge I_CLK);
        I_START = 1'b1; I_RS = 1'b1; I_POLL = 1'b0;
        @(posedge I_CLK);
        #1 I_START = 1'b0;
        repeat (10) @(negedge I_CLK);
        check("pre_rst_en", O_LCD_EN, 1);
        #1 I_RSTF = 1'b0;
        #1;
        check("arst_en", O_LCD_EN, 0);
        check("arst_rwf", O_LCD_RWF, 0);
        check("arst_busy", O_BUSY, 0);
        check("arst_oe", O_LCD_DATA_OE, 1);
        check("arst_done", O_DONE, 0);
        bad = 0;
        repeat (2) begin
            @(negedge I_CLK);
            if (O_DONE) bad++;
        end
        I_RSTF = 1'b1;
        repeat (60) begin
            @(negedge I_CLK);
            if (O_DONE || O_BUSY) bad++;
        end
        check("no_done_after_reset", bad, 0);
        tx_resp = '{8'h3C};
        run_txn(1'b1, 1'b0, 0);

        // Random reads and polls.
        for (int t = 0; t < 25; t++) begin
            logic rs_r, poll_r;
            logic [7:0] b;
            rs_r = 1'($urandom_range(0, 1));
            poll_r = 1'($urandom_range(0, 1));
            tx_resp.delete();
            for (int i = 0; i < PMAX; i++) begin
                b = 8'($urandom_range(0, 255));
                b[7] = ($urandom_range(0, 2) != 0);
                tx_resp.push_back(b);
            end
            run_txn(rs_r, poll_r, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
